fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the byte-addressed, big-endian memory block.
- Issues single-word reads (access_size 2'b00) at a sequential PC and captures the returned word.
- Presents instruction+PC to decode through a valid/ready handshake; accepts branch redirects.
- One-cycle memory read latency; sustains 1 instruction/cycle with no backpressure.

---
 rtl/fetch_unit.sv | 151 +++++++++++++++
 tb/tb_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: sequential single-word reads, 1-entry skid, redirect flush.
// Optional FETCH_ALIGN_CHECK_EN adds alignment/range faulting of the fetch PC.
module fetch_unit #(
   parameter int unsigned          ADDR_W     = 32,
   parameter int unsigned          DATA_W     = 32,
   parameter logic [ADDR_W-1:0]    START_ADDR = 32'h8002_0000,
   parameter int unsigned          DEPTH      = 1048576
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              run,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              out_ready,
   output logic              insn_valid,
   output logic [DATA_W-1:0] insn,
   output logic [ADDR_W-1:0] insn_pc,
   output logic              fetch_fault,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_in,
   output logic [1:0]        mem_access_size,
   output logic              mem_rw,
   output logic              mem_enable,
   input  logic              mem_busy,
   input  logic [DATA_W-1:0] mem_data_out
);

   logic [ADDR_W-1:0] pc_r;
   logic [ADDR_W-1:0] req_pc_r;
   logic              pending_r;
   logic              skid_valid_r;
   logic [DATA_W-1:0] skid_insn_r;
   logic [ADDR_W-1:0] skid_pc_r;
   logic              insn_valid_r;
   logic [DATA_W-1:0] insn_r;
   logic [ADDR_W-1:0] insn_pc_r;
   logic              fetch_fault_r;

   logic              pc_bad_s;
   logic [ADDR_W-1:0] redirect_target_s;
   logic              can_go_s;
   logic              stall_s;
   logic              issue_s;
   logic              fault_s;
   logic              resp_s;
   logic              consume_s;

`ifdef FETCH_ALIGN_CHECK_EN
   localparam logic [ADDR_W:0] WIN_LO = {1'b0, START_ADDR};
   localparam logic [ADDR_W:0] WIN_HI = {1'b0, START_ADDR} + (ADDR_W+1)'(DEPTH);

   // Classify the current PC as misaligned or outside the memory window
   always_comb begin
      pc_bad_s          = (pc_r[1:0] != 2'b00) ||
                          ({1'b0, pc_r} < WIN_LO) ||
                          ({1'b0, pc_r} >= WIN_HI);
      redirect_target_s = redirect_pc;
   end
`else
   logic unused_redirect_lsb_s;
   assign unused_redirect_lsb_s = &{1'b0, redirect_pc[1:0]};

   // Without checking, targets are word-aligned by dropping the low bits
   always_comb begin
      pc_bad_s          = 1'b0;
      redirect_target_s = {redirect_pc[ADDR_W-1:2], 2'b00};
   end
`endif

   // Issue, fault, response and handshake qualifiers for the current cycle
   always_comb begin
      stall_s   = insn_valid_r && !out_ready;
      can_go_s  = run && !reset && !redirect_valid && !mem_busy &&
                  !skid_valid_r && !fetch_fault_r;
      issue_s   = can_go_s && !stall_s && !pc_bad_s;
      // A fault is only raised once older instructions have fully drained
      fault_s   = can_go_s && !insn_valid_r && !pending_r && pc_bad_s;
      resp_s    = pending_r && !mem_busy;
      consume_s = insn_valid_r && out_ready;
   end

   // PC, request tracking, output register and skid buffer
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_r          <= START_ADDR;
         req_pc_r      <= START_ADDR;
         pending_r     <= 1'b0;
         skid_valid_r  <= 1'b0;
         skid_insn_r   <= {DATA_W{1'b0}};
         skid_pc_r     <= {ADDR_W{1'b0}};
         insn_valid_r  <= 1'b0;
         insn_r        <= {DATA_W{1'b0}};
         insn_pc_r     <= {ADDR_W{1'b0}};
         fetch_fault_r <= 1'b0;
      end else if (redirect_valid) begin
         pc_r          <= redirect_target_s;
         pending_r     <= 1'b0;
         skid_valid_r  <= 1'b0;
         insn_valid_r  <= 1'b0;
         fetch_fault_r <= 1'b0;
      end else begin
         if (issue_s) begin
            pending_r <= 1'b1;
            req_pc_r  <= pc_r;
            pc_r      <= pc_r + ADDR_W'(32'd4);
         end else if (resp_s) begin
            pending_r <= 1'b0;
         end

         if (fault_s) begin
            fetch_fault_r <= 1'b1;
            insn_pc_r     <= pc_r;
         end

         // Skid content is always older than a response arriving now
         if (!insn_valid_r || consume_s) begin
            if (skid_valid_r) begin
               insn_r       <= skid_insn_r;
               insn_pc_r    <= skid_pc_r;
               insn_valid_r <= 1'b1;
               skid_valid_r <= resp_s;
               if (resp_s) begin
                  skid_insn_r <= mem_data_out;
                  skid_pc_r   <= req_pc_r;
               end
            end else if (resp_s) begin
               insn_r       <= mem_data_out;
               insn_pc_r    <= req_pc_r;
               insn_valid_r <= 1'b1;
            end else begin
               insn_valid_r <= 1'b0;
            end
         end else if (resp_s) begin
            skid_insn_r  <= mem_data_out;
            skid_pc_r    <= req_pc_r;
            skid_valid_r <= 1'b1;
         end
      end
   end

   assign insn_valid      = insn_valid_r;
   assign insn            = insn_r;
   assign insn_pc         = insn_pc_r;
   assign fetch_fault     = fetch_fault_r;
   assign mem_enable      = issue_s;
   assign mem_address     = pc_r;
   assign mem_data_in     = {DATA_W{1'b0}};
   assign mem_access_size = 2'b00;
   assign mem_rw          = 1'b1;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table plus directed corner-case sequences.
module tb_fetch_unit;

   localparam logic [31:0] S = 32'h8002_0000;

   logic        clock = 1'b0;
   logic        reset, run, redirect_valid, out_ready, mem_busy;
   logic [31:0] redirect_pc;
   logic        insn_valid, fetch_fault, mem_rw, mem_enable;
   logic [31:0] insn, insn_pc, mem_address, mem_data_in, mem_data_out;
   logic [1:0]  mem_access_size;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   fetch_unit dut (
      .clock(clock), .reset(reset), .run(run),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_ready(out_ready), .insn_valid(insn_valid), .insn(insn),
      .insn_pc(insn_pc), .fetch_fault(fetch_fault),
      .mem_address(mem_address), .mem_data_in(mem_data_in),
      .mem_access_size(mem_access_size), .mem_rw(mem_rw),
      .mem_enable(mem_enable), .mem_busy(mem_busy),
      .mem_data_out(mem_data_out)
   );

   // Preloaded words: 0x11111111 * (k+1) for the first 15 words, else a tagged address
   function automatic logic [31:0] word_at(input logic [31:0] a);
      logic [31:0] off;
      off = a - S;
      if (a >= S && off < 32'd60) word_at = 32'h1111_1111 * ((off >> 2) + 32'd1);
      else                        word_at = {16'hC0DE, a[15:0]};
   endfunction

   // One-cycle-latency read memory; data holds until the next accepted request
   always @(posedge clock) begin
      if (mem_enable && !mem_busy) mem_data_out <= word_at(mem_address);
   end

   typedef struct {
      logic        rst, run, rv;
      logic [31:0] rpc;
      logic        rdy, busy;
      logic        cout, ev;
      logic [31:0] ei, ep;
      logic        cmem, een;
      logic [31:0] ea;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic rst, input logic r, input logic rv,
                               input logic [31:0] rpc, input logic rdy, input logic busy,
                               input logic cout, input logic ev, input logic [31:0] ei,
                               input logic [31:0] ep, input logic cmem, input logic een,
                               input logic [31:0] ea);
      vec_t v;
      v.rst = rst; v.run = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.busy = busy;
      v.cout = cout; v.ev = ev; v.ei = ei; v.ep = ep; v.cmem = cmem; v.een = een; v.ea = ea;
      return v;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rst, input logic r, input logic rv, input logic [31:0] rpc,
                        input logic rdy, input logic busy);
      reset = rst; run = r; redirect_valid = rv; redirect_pc = rpc;
      out_ready = rdy; mem_busy = busy;
      #1;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0); tick();
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0); tick();
   endtask

   initial begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      tick();

      // Stream, 3-cycle backpressure, then restart and redirect with 0x80020010 in flight
      for (int k = 0; k < 2; k++) begin
         tbl.push_back(mk(1,0,0,0,1,0, 0,0,0,0, 1,0,0));
         tbl.push_back(mk(1,0,0,0,1,0, 0,0,0,0, 1,0,0));
         tbl.push_back(mk(0,1,0,0,1,0, 1,0,0,0, 1,1,S));
         tbl.push_back(mk(0,1,0,0,1,0, 1,0,0,0, 1,1,S+32'h4));
         tbl.push_back(mk(0,1,0,0,1,0, 1,1,32'h1111_1111,S, 1,1,S+32'h8));
         tbl.push_back(mk(0,1,0,0,1,0, 1,1,32'h2222_2222,S+32'h4, 1,1,S+32'hC));
         if (k == 0) begin
            tbl.push_back(mk(0,1,0,0,0,0, 1,1,32'h3333_3333,S+32'h8, 1,0,0));
            tbl.push_back(mk(0,1,0,0,0,0, 1,1,32'h3333_3333,S+32'h8, 1,0,0));
            tbl.push_back(mk(0,1,0,0,0,0, 1,1,32'h3333_3333,S+32'h8, 1,0,0));
            tbl.push_back(mk(0,1,0,0,1,0, 1,1,32'h3333_3333,S+32'h8, 1,0,0));
            tbl.push_back(mk(0,1,0,0,1,0, 1,1,32'h4444_4444,S+32'hC, 1,1,S+32'h10));
            tbl.push_back(mk(0,1,0,0,1,0, 1,0,0,0, 1,1,S+32'h14));
            tbl.push_back(mk(0,1,0,0,1,0, 1,1,32'h5555_5555,S+32'h10, 1,1,S+32'h18));
            tbl.push_back(mk(0,1,0,0,1,0, 1,1,32'h6666_6666,S+32'h14, 1,1,S+32'h1C));
         end else begin
            tbl.push_back(mk(0,1,0,0,1,0, 1,1,32'h3333_3333,S+32'h8, 1,1,S+32'h10));
            tbl.push_back(mk(0,1,1,32'h8002_0100,1,0, 1,1,32'h4444_4444,S+32'hC, 1,0,0));
            tbl.push_back(mk(0,1,0,0,1,0, 1,0,0,0, 1,1,32'h8002_0100));
            tbl.push_back(mk(0,1,0,0,1,0, 1,0,0,0, 1,1,32'h8002_0104));
            tbl.push_back(mk(0,1,0,0,1,0, 1,1,32'hC0DE_0100,32'h8002_0100, 1,1,32'h8002_0108));
            tbl.push_back(mk(0,1,0,0,1,0, 1,1,32'hC0DE_0104,32'h8002_0104, 1,1,32'h8002_010C));
            // run dropped with a request in flight: response still lands (skid), no new issue
            tbl.push_back(mk(0,0,0,0,0,0, 1,1,32'hC0DE_0108,32'h8002_0108, 1,0,0));
            tbl.push_back(mk(0,0,0,0,1,0, 1,1,32'hC0DE_0108,32'h8002_0108, 1,0,0));
            tbl.push_back(mk(0,0,0,0,1,0, 1,1,32'hC0DE_010C,32'h8002_010C, 1,0,0));
            tbl.push_back(mk(0,0,0,0,1,0, 1,0,0,0, 1,0,0));
         end
      end

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].run, tbl[i].rv, tbl[i].rpc, tbl[i].rdy, tbl[i].busy);
         if (tbl[i].cout) begin
            cmp($sformatf("v%0d insn_valid", i), {31'd0, insn_valid}, {31'd0, tbl[i].ev});
            if (tbl[i].ev) begin
               cmp($sformatf("v%0d insn", i), insn, tbl[i].ei);
               cmp($sformatf("v%0d insn_pc", i), insn_pc, tbl[i].ep);
            end
         end
         if (tbl[i].cmem) begin
            cmp($sformatf("v%0d mem_enable", i), {31'd0, mem_enable}, {31'd0, tbl[i].een});
            if (tbl[i].een) cmp($sformatf("v%0d mem_address", i), mem_address, tbl[i].ea);
         end
         cmp($sformatf("v%0d mem_rw", i), {31'd0, mem_rw}, 32'd1);
         cmp($sformatf("v%0d mem_access_size", i), {30'd0, mem_access_size}, 32'd0);
         cmp($sformatf("v%0d mem_data_in", i), mem_data_in, 32'd0);
         tick();
      end

      // mem_busy held for 2 cycles while a response is pending
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      cmp("busy issue0 addr", mem_address, S);
      cmp("busy issue0 en", {31'd0, mem_enable}, 32'd1);
      tick();
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      cmp("busy1 en", {31'd0, mem_enable}, 32'd0);
      tick();
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      cmp("busy2 en", {31'd0, mem_enable}, 32'd0);
      cmp("busy2 valid", {31'd0, insn_valid}, 32'd0);
      tick();
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      cmp("busy release valid", {31'd0, insn_valid}, 32'd0);
      cmp("busy release en", {31'd0, mem_enable}, 32'd1);
      cmp("busy release addr", mem_address, S + 32'h4);
      tick();
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      cmp("busy capture valid", {31'd0, insn_valid}, 32'd1);
      cmp("busy capture insn", insn, 32'h1111_1111);
      cmp("busy capture pc", insn_pc, S);
      tick();
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      cmp("busy next pc", insn_pc, S + 32'h4);
      tick();

      // Reset while insn_valid is high discards the stream and in-flight response
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      cmp("pre-reset valid", {31'd0, insn_valid}, 32'd1);
      tick();
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      cmp("post-reset valid", {31'd0, insn_valid}, 32'd0);
      cmp("post-reset pc", mem_address, S);
      cmp("post-reset en", {31'd0, mem_enable}, 32'd1);
      cmp("post-reset insn", insn, 32'd0);
      cmp("post-reset fault", {31'd0, fetch_fault}, 32'd0);
      tick();
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      cmp("post-reset c1 valid", {31'd0, insn_valid}, 32'd0);
      tick();
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      cmp("post-reset first valid", {31'd0, insn_valid}, 32'd1);
      cmp("post-reset first pc", insn_pc, S);
      cmp("post-reset first insn", insn, 32'h1111_1111);
      tick();

      // Redirect to a misaligned target
      drive(1'b0, 1'b1, 1'b1, 32'h8002_0002, 1'b1, 1'b0);
      tick();
`ifdef FETCH_ALIGN_CHECK_EN
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      cmp("align c1 en", {31'd0, mem_enable}, 32'd0);
      tick();
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      cmp("align fault", {31'd0, fetch_fault}, 32'd1);
      cmp("align fault pc", insn_pc, 32'h8002_0002);
      cmp("align fault valid", {31'd0, insn_valid}, 32'd0);
      cmp("align fault en", {31'd0, mem_enable}, 32'd0);
      tick();
      drive(1'b0, 1'b1, 1'b1, 32'h8002_0004, 1'b1, 1'b0);
      cmp("align sticky", {31'd0, fetch_fault}, 32'd1);
      tick();
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      cmp("align cleared", {31'd0, fetch_fault}, 32'd0);
      cmp("align resume addr", mem_address, S + 32'h4);
      cmp("align resume en", {31'd0, mem_enable}, 32'd1);
      tick();
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0); tick();
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      cmp("align resume pc", insn_pc, S + 32'h4);
      cmp("align resume insn", insn, 32'h2222_2222);
      tick();
      // Range: first address past the window faults, last word of the window fetches
      drive(1'b0, 1'b1, 1'b1, 32'h8012_0000, 1'b1, 1'b0); tick();
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      cmp("range end en", {31'd0, mem_enable}, 32'd0);
      tick();
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      cmp("range end fault", {31'd0, fetch_fault}, 32'd1);
      tick();
      drive(1'b0, 1'b1, 1'b1, 32'h8011_FFFC, 1'b1, 1'b0); tick();
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      cmp("range last en", {31'd0, mem_enable}, 32'd1);
      cmp("range last addr", mem_address, 32'h8011_FFFC);
      tick();
`else
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      cmp("lsb ignored addr", mem_address, S);
      cmp("lsb ignored en", {31'd0, mem_enable}, 32'd1);
      tick();
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0); tick();
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      cmp("lsb ignored pc", insn_pc, S);
      cmp("lsb ignored insn", insn, 32'h1111_1111);
      cmp("no fault", {31'd0, fetch_fault}, 32'd0);
      tick();
      // PC wraps silently past the top of the address space
      drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0); tick();
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      cmp("wrap addr0", mem_address, 32'hFFFF_FFFC);
      tick();
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      cmp("wrap addr1", mem_address, 32'h0000_0000);
      tick();
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      cmp("wrap pc0", insn_pc, 32'hFFFF_FFFC);
      cmp("wrap insn0", insn, 32'hC0DE_FFFC);
      tick();
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      cmp("wrap pc1", insn_pc, 32'h0000_0000);
      cmp("wrap insn1", insn, 32'hC0DE_0000);
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
